// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of the combinational 8-bit ALU.
// Accepts one command at a time on a valid/ready request channel, registers
// operands/opcode onto the ALU bus for a single execute cycle, captures the
// ALU result and holds it on a valid/ready response channel.
// Optional feature: define ALU_SEQ_CHAIN_EN to keep a last-result register
// that a chained command (cmd_chain=1) uses in place of cmd_a.
module alu_cmd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_chain,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic       op_legal;
    logic [7:0] next_a;

    // Handshake flags are pure decodes of the state, so reset values follow
    // automatically from state=IDLE.
    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // Opcodes 110 and 111 have no ALU function.
    assign op_legal  = (cmd_op <= 3'd5);

`ifdef ALU_SEQ_CHAIN_EN
    logic [7:0] last_result;

    assign next_a = cmd_chain ? last_result : cmd_a;

    // Last-result register: refreshed only by executed (legal) commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_result <= 8'h00;
        end else if (state == ST_EXEC) begin
            last_result <= alu_out;
        end
    end
`else
    logic unused_chain;

    assign unused_chain = cmd_chain;
    assign next_a       = cmd_a;
`endif

    // Main sequencer: state, ALU operand bus and response registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it also overrides a
        // command presented in the same cycle; all state uses non-blocking
        // assignments so every register sees pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_opcode <= 3'b000;
            rsp_data   <= 8'h00;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (op_legal) begin
                            alu_a      <= next_a;
                            alu_b      <= cmd_b;
                            alu_opcode <= cmd_op;
                            state      <= ST_EXEC;
                        end else begin
                            // Illegal command skips the ALU; its bus keeps
                            // the previous operands.
                            rsp_data <= 8'h00;
                            rsp_err  <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_data <= alu_out;
                    rsp_err  <= 1'b0;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
